axi_burst_addr_gen: RTL and testbench

//  Parametrised AXI address-channel burst generator for the memcopy engines (read or write side).

---
 rtl/memcopy_pkg.sv | 29 ++
 rtl/burst_len_calc.sv | 58 +++++
 rtl/axi_burst_addr_gen.sv | 193 +++++++++++++++++++
 tb/tb_axi_burst_addr_gen.sv | 371 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/memcopy_pkg.sv
// Shared definitions for the memcopy address-channel burst generators.
package memcopy_pkg;

  // One-hot controller states.
  typedef enum logic [4:0] {
    ST_IDLE  = 5'b00001,
    ST_CALC  = 5'b00010,
    ST_SEND  = 5'b00100,
    ST_DRAIN = 5'b01000,
    ST_DONE  = 5'b10000
  } state_e;

  // AXI bursts must not cross a 4KB page.
  localparam int unsigned PAGE_BYTES = 4096;
  localparam int unsigned PAGE_SHIFT = 12;

  localparam int unsigned DEF_DATA_WIDTH = 512;

  // Bytes per beat for a given AXI data width.
  function automatic int unsigned beat_bytes(input int unsigned data_width);
    return data_width / 8;
  endfunction

  // log2 of the beat size; converts beat counts to byte offsets.
  function automatic int unsigned beat_shift(input int unsigned data_width);
    return $clog2(data_width / 8);
  endfunction

endpackage

// File: rtl/burst_len_calc.sv
// Burst sizing and next-address generation for the AXI burst generator.
// blen_o  = min(len_cfg+1, beats left in the 4KB page, remaining beats).
// next_addr_o = address after a burst of blen_cur_i beats, folded back
// into the 2^(12+wrap_len) window when wrap mode is on.
module burst_len_calc
  import memcopy_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 64,
  parameter int unsigned CNT_WIDTH  = 40,
  parameter int unsigned BEAT_SHIFT = 6
) (
  input  logic [ADDR_WIDTH-1:0] cur_addr_i,
  input  logic [CNT_WIDTH-1:0]  remain_i,
  input  logic [7:0]            len_cfg_i,
  input  logic [8:0]            blen_cur_i,
  input  logic                  wrap_mode_i,
  input  logic [3:0]            wrap_len_i,
  input  logic [ADDR_WIDTH-1:0] wrap_base_i,
  output logic [8:0]            blen_o,
  output logic [ADDR_WIDTH-1:0] next_addr_o
);

  localparam int unsigned PW = PAGE_SHIFT + 1;

  logic [PW-1:0]         page_left;
  logic [PW-1:0]         beats_to_page;
  logic [PW-1:0]         cap_cfg;
  logic [PW-1:0]         cap;
  logic [ADDR_WIDTH-1:0] incr_addr;
  logic [ADDR_WIDTH-1:0] win_mask;
  logic [4:0]            win_shift;

  // Burst length: the smallest of the configured cap, page room and remainder.
  always_comb begin
    page_left     = PW'(PAGE_BYTES) - {1'b0, cur_addr_i[PAGE_SHIFT-1:0]};
    beats_to_page = page_left >> BEAT_SHIFT;
    cap_cfg       = {{(PW-8){1'b0}}, len_cfg_i} + PW'(1);
    cap           = (beats_to_page < cap_cfg) ? beats_to_page : cap_cfg;
    if (remain_i < CNT_WIDTH'(cap)) begin
      blen_o = remain_i[8:0];
    end else begin
      blen_o = cap[8:0];
    end
  end

  // Next burst address, with the high bits pinned to the window base in wrap mode.
  always_comb begin
    incr_addr = cur_addr_i + (ADDR_WIDTH'(blen_cur_i) << BEAT_SHIFT);
    win_shift = 5'(PAGE_SHIFT) + {1'b0, wrap_len_i};
    win_mask  = ~({ADDR_WIDTH{1'b1}} << win_shift);
    if (wrap_mode_i) begin
      next_addr_o = (wrap_base_i & ~win_mask) | (incr_addr & win_mask);
    end else begin
      next_addr_o = incr_addr;
    end
  end

endmodule

// File: rtl/axi_burst_addr_gen.sv
// AXI AR/AW burst generator for the memcopy engines.
// Splits a job of total_beats beats into INCR bursts, limited by the
// configured length, 4KB pages, an optional wrap window and a credit limit
// on outstanding bursts.
//
// state  | meaning
// IDLE   | waiting for start
// CALC   | size the next burst, wait for a credit, or leave on abort/empty
// SEND   | address valid, held stable until axi_ready
// DRAIN  | no more bursts; wait for all responses
// DONE   | one-cycle done pulse
module axi_burst_addr_gen
  import memcopy_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH      = 64,
  parameter int unsigned DATA_WIDTH      = DEF_DATA_WIDTH,
  parameter int unsigned CNT_WIDTH       = 40,
  parameter int unsigned MAX_OUTSTANDING = 8
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               start,
  input  logic                               wrap_mode,
  input  logic [3:0]                         wrap_len,
  input  logic [ADDR_WIDTH-1:0]              start_addr,
  input  logic [CNT_WIDTH-1:0]               total_beats,
  input  logic [7:0]                         burst_len_cfg,
  input  logic                               abort,
  output logic [ADDR_WIDTH-1:0]              axi_addr,
  output logic [7:0]                         axi_len,
  output logic                               axi_valid,
  input  logic                               axi_ready,
  input  logic                               resp_done,
  output logic                               busy,
  output logic                               done,
  output logic                               aborted,
  output logic [$clog2(MAX_OUTSTANDING):0]   outstanding
);

  localparam int unsigned BEAT_BYTES = beat_bytes(DATA_WIDTH);
  localparam int unsigned BEAT_SHIFT = beat_shift(DATA_WIDTH);
  localparam int unsigned OW         = $clog2(MAX_OUTSTANDING) + 1;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cur_addr_q, cur_addr_d;
  logic [ADDR_WIDTH-1:0] base_addr_q, base_addr_d;
  logic [CNT_WIDTH-1:0]  remain_q, remain_d;
  logic [7:0]            len_q, len_d;
  logic [7:0]            cfg_q, cfg_d;
  logic                  wrap_mode_q, wrap_mode_d;
  logic [3:0]            wrap_len_q, wrap_len_d;
  logic [OW-1:0]         out_q, out_d;
  logic                  aborted_q, aborted_d;
  logic                  abort_pend_q, abort_pend_d;

  logic [8:0]            blen_cur;
  logic [8:0]            blen_w;
  logic [ADDR_WIDTH-1:0] next_addr_w;
  logic                  credit_ok;
  logic                  hs;
  logic                  rsp;

  assign blen_cur  = 9'(len_q) + 9'd1;
  assign credit_ok = (out_q < OW'(MAX_OUTSTANDING));
  assign hs        = (state_q == ST_SEND) && axi_ready;
  assign rsp       = resp_done && (out_q != '0);

  burst_len_calc #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .CNT_WIDTH  (CNT_WIDTH),
    .BEAT_SHIFT (BEAT_SHIFT)
  ) u_len_calc (
    .cur_addr_i  (cur_addr_q),
    .remain_i    (remain_q),
    .len_cfg_i   (cfg_q),
    .blen_cur_i  (blen_cur),
    .wrap_mode_i (wrap_mode_q),
    .wrap_len_i  (wrap_len_q),
    .wrap_base_i (base_addr_q),
    .blen_o      (blen_w),
    .next_addr_o (next_addr_w)
  );

  // Controller next-state and job bookkeeping.
  always_comb begin
    state_d      = state_q;
    cur_addr_d   = cur_addr_q;
    base_addr_d  = base_addr_q;
    remain_d     = remain_q;
    len_d        = len_q;
    cfg_d        = cfg_q;
    wrap_mode_d  = wrap_mode_q;
    wrap_len_d   = wrap_len_q;
    aborted_d    = aborted_q;
    abort_pend_d = abort_pend_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          cur_addr_d   = start_addr & ~ADDR_WIDTH'(BEAT_BYTES - 1);
          base_addr_d  = start_addr;
          remain_d     = total_beats;
          cfg_d        = burst_len_cfg;
          wrap_mode_d  = wrap_mode;
          wrap_len_d   = wrap_len;
          aborted_d    = 1'b0;
          abort_pend_d = 1'b0;
          state_d      = ST_CALC;
        end
      end
      ST_CALC: begin
        if ((remain_q == '0) || abort) begin
          abort_pend_d = (remain_q != '0);
          state_d      = ST_DRAIN;
        end else begin
          len_d = 8'(blen_w - 9'd1);
          if (credit_ok) begin
            state_d = ST_SEND;
          end
        end
      end
      ST_SEND: begin
        // Abort is only looked at in CALC so the handshake is never broken.
        if (axi_ready) begin
          remain_d   = remain_q - CNT_WIDTH'(blen_cur);
          cur_addr_d = next_addr_w;
          state_d    = ST_CALC;
        end
      end
      ST_DRAIN: begin
        if (out_q == '0) begin
          if (abort_pend_q) begin
            aborted_d = 1'b1;
          end
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outstanding-burst credit counter; a response with nothing in flight is dropped.
  always_comb begin
    out_d = out_q;
    case ({hs, rsp})
      2'b10:   out_d = out_q + OW'(1);
      2'b01:   out_d = out_q - OW'(1);
      default: out_d = out_q;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cur_addr_q   <= '0;
      base_addr_q  <= '0;
      remain_q     <= '0;
      len_q        <= '0;
      cfg_q        <= '0;
      wrap_mode_q  <= 1'b0;
      wrap_len_q   <= '0;
      out_q        <= '0;
      aborted_q    <= 1'b0;
      abort_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cur_addr_q   <= cur_addr_d;
      base_addr_q  <= base_addr_d;
      remain_q     <= remain_d;
      len_q        <= len_d;
      cfg_q        <= cfg_d;
      wrap_mode_q  <= wrap_mode_d;
      wrap_len_q   <= wrap_len_d;
      out_q        <= out_d;
      aborted_q    <= aborted_d;
      abort_pend_q <= abort_pend_d;
    end
  end

  assign axi_valid   = (state_q == ST_SEND);
  assign axi_addr    = cur_addr_q;
  assign axi_len     = len_q;
  assign busy        = (state_q != ST_IDLE);
  assign done        = (state_q == ST_DONE);
  assign aborted     = aborted_q;
  assign outstanding = out_q;

endmodule

// File: tb/tb_axi_burst_addr_gen.sv
// Testbench for axi_burst_addr_gen with 64-byte beats and a 2-burst credit limit.
module tb_axi_burst_addr_gen;

  localparam int AW = 64;
  localparam int DW = 512;
  localparam int CW = 40;
  localparam int MO = 2;
  localparam int BB = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          wrap_mode;
  logic [3:0]    wrap_len;
  logic [AW-1:0] start_addr;
  logic [CW-1:0] total_beats;
  logic [7:0]    burst_len_cfg;
  logic          abort;
  logic [AW-1:0] axi_addr;
  logic [7:0]    axi_len;
  logic          axi_valid;
  logic          axi_ready;
  logic          resp_done;
  logic          busy;
  logic          done;
  logic          aborted;
  logic [1:0]    outstanding;

  int errors = 0;
  int checks = 0;

  longint unsigned exp_a[$];
  int              exp_l[$];
  longint unsigned obs_a[$];
  int              obs_l[$];
  int              lat_first;
  int              min_gap;

  always #5 clk = ~clk;

  axi_burst_addr_gen #(
    .ADDR_WIDTH      (AW),
    .DATA_WIDTH      (DW),
    .CNT_WIDTH       (CW),
    .MAX_OUTSTANDING (MO)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .wrap_mode     (wrap_mode),
    .wrap_len      (wrap_len),
    .start_addr    (start_addr),
    .total_beats   (total_beats),
    .burst_len_cfg (burst_len_cfg),
    .abort         (abort),
    .axi_addr      (axi_addr),
    .axi_len       (axi_len),
    .axi_valid     (axi_valid),
    .axi_ready     (axi_ready),
    .resp_done     (resp_done),
    .busy          (busy),
    .done          (done),
    .aborted       (aborted),
    .outstanding   (outstanding)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected burst list from the splitting rules, one burst at a time.
  task automatic build_model(input longint unsigned addr, input longint unsigned total,
                             input int cfg, input bit wm, input int wl);
    longint unsigned a, rem, to4k, b, win;
    exp_a.delete();
    exp_l.delete();
    a   = addr - (addr % BB);
    rem = total;
    win = 64'd1 << (12 + wl);
    while (rem > 0) begin
      to4k = (4096 - (a % 4096)) / BB;
      b    = longint'(cfg) + 1;
      if (to4k < b) b = to4k;
      if (rem < b) b = rem;
      exp_a.push_back(a);
      exp_l.push_back(int'(b) - 1);
      rem = rem - b;
      a   = a + b * BB;
      if (wm) a = (addr / win) * win + (a % win);
    end
  endtask

  task automatic expect_burst(input int i, input longint unsigned a, input int l);
    if (i < obs_a.size()) begin
      chk("directed_addr", obs_a[i], a);
      chk("directed_len", 64'(obs_l[i]), 64'(l));
    end else begin
      chk("directed_missing_burst", 64'(obs_a.size()), 64'(i + 1));
    end
  endtask

  task automatic wait_valid(input int budget);
    for (int k = 0; k < budget; k++) begin
      if (axi_valid) break;
      tick();
    end
    chk("wait_valid", axi_valid, 1);
  endtask

  // Runs one job to its done pulse, checking every burst, the credit count and stability.
  task automatic run_job(input longint unsigned addr, input longint unsigned total,
                         input int cfg, input bit wm, input int wl,
                         input int ready_pct, input int resp_pct, input bit noise);
    int  cyc, last_hs, out_m;
    bit  fin, prev_valid, prev_stall, hsv, rspv;
    logic [63:0] prev_a;
    logic [7:0]  prev_l;
    build_model(addr, total, cfg, wm, wl);
    obs_a.delete();
    obs_l.delete();
    start_addr    = addr;
    total_beats   = CW'(total);
    burst_len_cfg = 8'(cfg);
    wrap_mode     = wm;
    wrap_len      = 4'(wl);
    axi_ready     = 1'b0;
    resp_done     = 1'b0;
    start         = 1'b1;
    tick();
    start      = 1'b0;
    cyc        = 1;
    out_m      = 0;
    last_hs    = -1000;
    lat_first  = -1;
    min_gap    = 1000;
    fin        = 1'b0;
    prev_valid = 1'b0;
    prev_stall = 1'b0;
    prev_a     = '0;
    prev_l     = '0;
    for (int k = 0; k < 4000 && !fin; k++) begin
      chk("outstanding", 64'(outstanding), 64'(out_m));
      if (axi_valid) begin
        if (lat_first < 0) lat_first = cyc;
        if (!prev_valid && (cyc - last_hs) < min_gap) min_gap = cyc - last_hs;
        chk("credit_gate", 64'(out_m < MO), 1);
        if (prev_stall) begin
          chk("stall_addr", axi_addr, prev_a);
          chk("stall_len", 64'(axi_len), 64'(prev_l));
        end
      end
      if (done) begin
        chk("done_outstanding", 64'(out_m), 0);
        fin       = 1'b1;
        start     = 1'b0;
        axi_ready = 1'b0;
        resp_done = 1'b0;
      end else begin
        axi_ready = ($urandom_range(0, 99) < ready_pct);
        resp_done = ($urandom_range(0, 99) < resp_pct);
        start     = noise && ($urandom_range(0, 15) == 0);
        if (start) begin
          start_addr  = AW'($urandom);
          total_beats = CW'($urandom_range(1, 50));
        end
        hsv  = axi_valid && axi_ready;
        rspv = resp_done && (out_m > 0);
        if (hsv) begin
          obs_a.push_back(axi_addr);
          obs_l.push_back(int'(axi_len));
          last_hs = cyc;
        end
        if (hsv && !rspv) out_m++;
        else if (!hsv && rspv) out_m--;
        prev_valid = axi_valid;
        prev_stall = axi_valid && !axi_ready;
        prev_a     = axi_addr;
        prev_l     = axi_len;
        tick();
        cyc++;
      end
    end
    start = 1'b0;
    chk("job_finished", 64'(fin), 1);
    if (!fin) begin
      rst = 1'b1;
      tick();
      rst = 1'b0;
    end
    tick();
    chk("idle_after_done_busy", busy, 0);
    chk("idle_after_done_pulse", done, 0);
    chk("burst_count", 64'(obs_a.size()), 64'(exp_a.size()));
    for (int i = 0; i < exp_a.size() && i < obs_a.size(); i++) begin
      chk("burst_addr", obs_a[i], exp_a[i]);
      chk("burst_len", 64'(obs_l[i]), 64'(exp_l[i]));
    end
    if (exp_a.size() > 0) chk("first_valid_latency", 64'(lat_first), 2);
    if (exp_a.size() > 1) chk("calc_bubble", 64'(min_gap >= 2), 1);
  endtask

  initial begin
    int hs_n;
    rst           = 1'b1;
    start         = 1'b0;
    wrap_mode     = 1'b0;
    wrap_len      = '0;
    start_addr    = '0;
    total_beats   = '0;
    burst_len_cfg = '0;
    abort         = 1'b0;
    axi_ready     = 1'b0;
    resp_done     = 1'b0;
    tick(); tick(); tick();
    chk("rst_valid", axi_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_aborted", aborted, 0);
    chk("rst_outstanding", 64'(outstanding), 0);
    chk("rst_addr", axi_addr, 0);
    chk("rst_len", 64'(axi_len), 0);
    rst = 1'b0;
    tick();

    // Plain split at 32 beats, always ready, responses every cycle.
    run_job(64'h1000, 128, 31, 1'b0, 0, 100, 100, 1'b0);
    chk("t1_count", 64'(obs_a.size()), 4);
    expect_burst(0, 64'h1000, 31);
    expect_burst(1, 64'h1800, 31);
    expect_burst(2, 64'h2000, 31);
    expect_burst(3, 64'h2800, 31);

    // 4KB page boundary.
    run_job(64'h1F80, 10, 15, 1'b0, 0, 100, 100, 1'b0);
    chk("t2_count", 64'(obs_a.size()), 2);
    expect_burst(0, 64'h1F80, 1);
    expect_burst(1, 64'h2000, 7);

    // Wrap inside a 4KB window.
    run_job(64'h3F00, 16, 7, 1'b1, 0, 100, 100, 1'b0);
    chk("t3_count", 64'(obs_a.size()), 3);
    expect_burst(0, 64'h3F00, 3);
    expect_burst(1, 64'h3000, 7);
    expect_burst(2, 64'h3200, 3);

    // Credit limit: two bursts issue, then the generator stalls.
    start_addr = '0; total_beats = 64; burst_len_cfg = 7; wrap_mode = 1'b0;
    axi_ready = 1'b1; resp_done = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    hs_n = 0;
    for (int k = 0; k < 12; k++) begin
      if (axi_valid && axi_ready) hs_n++;
      tick();
    end
    chk("credit_stall_handshakes", 64'(hs_n), 2);
    chk("credit_stall_valid", axi_valid, 0);
    chk("credit_stall_outstanding", 64'(outstanding), 2);
    resp_done = 1'b1;
    tick();
    resp_done = 1'b0;
    hs_n = 0;
    for (int k = 0; k < 6; k++) begin
      if (axi_valid && axi_ready) hs_n++;
      tick();
    end
    chk("credit_release_handshakes", 64'(hs_n), 1);
    chk("credit_release_outstanding", 64'(outstanding), 2);
    axi_ready = 1'b0;
    resp_done = 1'b1;
    tick();
    resp_done = 1'b0;
    wait_valid(10);
    axi_ready = 1'b1;
    resp_done = 1'b1;
    tick();
    axi_ready = 1'b0;
    resp_done = 1'b0;
    chk("coincident_outstanding", 64'(outstanding), 1);
    wait_valid(10);
    rst = 1'b1;
    tick();
    chk("rst_send_valid", axi_valid, 0);
    chk("rst_send_busy", busy, 0);
    chk("rst_send_outstanding", 64'(outstanding), 0);
    rst = 1'b0;
    tick();

    // Abort while an address is stalled.
    start_addr = 64'h10000; total_beats = 64; burst_len_cfg = 7;
    axi_ready = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    wait_valid(5);
    abort = 1'b1;
    for (int k = 0; k < 5; k++) begin
      chk("abort_hold_valid", axi_valid, 1);
      chk("abort_hold_addr", axi_addr, 64'h10000);
      chk("abort_hold_len", 64'(axi_len), 7);
      tick();
    end
    axi_ready = 1'b1;
    chk("abort_hs_valid", axi_valid, 1);
    tick();
    axi_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("abort_drain_valid", axi_valid, 0);
      chk("abort_drain_done", done, 0);
      chk("abort_drain_aborted", aborted, 0);
      chk("abort_drain_outstanding", 64'(outstanding), 1);
      tick();
    end
    resp_done = 1'b1;
    tick();
    resp_done = 1'b0;
    chk("abort_resp_outstanding", 64'(outstanding), 0);
    chk("abort_resp_done", done, 0);
    tick();
    chk("abort_done", done, 1);
    chk("abort_aborted", aborted, 1);
    tick();
    chk("abort_after_done", done, 0);
    chk("abort_after_busy", busy, 0);
    chk("abort_sticky", aborted, 1);
    abort = 1'b0;

    // Stray response while idle must not underflow.
    resp_done = 1'b1;
    tick();
    resp_done = 1'b0;
    chk("resp_saturate", 64'(outstanding), 0);

    // Zero-beat job.
    total_beats = '0; start = 1'b1;
    tick();
    start = 1'b0;
    chk("zero_busy", busy, 1);
    chk("zero_aborted_cleared", aborted, 0);
    chk("zero_done_1", done, 0);
    tick();
    chk("zero_done_2", done, 0);
    chk("zero_valid", axi_valid, 0);
    tick();
    chk("zero_done_3", done, 1);
    chk("zero_valid_3", axi_valid, 0);
    tick();
    chk("zero_done_after", done, 0);
    chk("zero_busy_after", busy, 0);

    // Randomized jobs against the burst-list model, with ignored starts mixed in.
    for (int j = 0; j < 10; j++) begin
      run_job(longint'($urandom) & 64'hFFFF_FFC0 | longint'($urandom_range(0, 63)),
              longint'($urandom_range(1, 300)), int'($urandom_range(0, 70)),
              bit'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
              int'($urandom_range(30, 100)), int'($urandom_range(20, 90)), 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
